// File: rtl/vga_timing_pkg.sv
// Shared 640x480 VGA timing constants, decoder state encoding and pixel width.
package vga_timing_pkg;

    localparam int RGB_W = 12;
    localparam int CNT_W = 10;
    localparam int SUM_W = 16;

    localparam int CLKS_PER_PIXEL_640 = 4;
    localparam int H_TOTAL_640        = 800;
    localparam int H_SYNC_640         = 96;
    localparam int H_ACT_START_640    = 144;
    localparam int H_ACTIVE_640       = 640;
    localparam int V_TOTAL_640        = 525;
    localparam int V_SYNC_640         = 2;
    localparam int V_ACT_START_640    = 35;
    localparam int V_ACTIVE_640       = 480;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        TRACK  = 2'd2
    } dec_state_t;

endpackage

// File: rtl/vga_sync_decoder_if.sv
// Connector-side VGA signals plus the decoder's recovered-timing outputs.
// master = the side driving the connector (generator / bench), slave = the decoder.
interface vga_sync_decoder_if;
    import vga_timing_pkg::*;

    logic             hSync;
    logic             vSync;
    logic [RGB_W-1:0] rgb;
    logic [CNT_W-1:0] hCount;
    logic [CNT_W-1:0] vCount;
    logic             pixValid;
    logic [RGB_W-1:0] pixel;
    logic             locked;
    logic             frameDone;
    logic [SUM_W-1:0] frameSum;
    logic [SUM_W-1:0] frameCount;
    logic             hErr;
    logic             vErr;

    modport master (
        output hSync, vSync, rgb,
        input  hCount, vCount, pixValid, pixel, locked, frameDone,
               frameSum, frameCount, hErr, vErr
    );

    modport slave (
        input  hSync, vSync, rgb,
        output hCount, vCount, pixValid, pixel, locked, frameDone,
               frameSum, frameCount, hErr, vErr
    );

endinterface

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer followed by a one-clock falling-edge pulse.
// Flops clear to 0 so a line that is already low at reset release never
// produces a spurious edge; only a genuine high->low transition does.
module sync_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic sig,
    output logic fall
);

    logic meta;
    logic sync_q;
    logic prev_q;

    // Synchronize the asynchronous sync line and keep one clock of history.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta   <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta   <= sig;
            sync_q <= meta;
            prev_q <= sync_q;
        end
    end

    assign fall = prev_q & ~sync_q;

endmodule

// File: rtl/vga_sync_decoder.sv
// Receive-side VGA monitor: recovers pixel position from hSync/vSync, checks
// the frame timing, samples active pixels and counts completed frames.
// Optional per-frame pixel checksum is built when VGA_DECODE_CHECKSUM_EN is
// defined; otherwise frameSum reads 0.
module vga_sync_decoder
    import vga_timing_pkg::*;
#(
    parameter int CLKS_PER_PIXEL = CLKS_PER_PIXEL_640,
    parameter int H_TOTAL        = H_TOTAL_640,
    parameter int H_SYNC         = H_SYNC_640,
    parameter int H_ACT_START    = H_ACT_START_640,
    parameter int H_ACTIVE       = H_ACTIVE_640,
    parameter int V_TOTAL        = V_TOTAL_640,
    parameter int V_SYNC         = V_SYNC_640,
    parameter int V_ACT_START    = V_ACT_START_640,
    parameter int V_ACTIVE       = V_ACTIVE_640
) (
    input logic               clk,
    input logic               reset,
    vga_sync_decoder_if.slave bus
);

    localparam int PH_W = (CLKS_PER_PIXEL > 1) ? $clog2(CLKS_PER_PIXEL) : 1;
    localparam logic [PH_W-1:0]  PH_LAST = PH_W'(CLKS_PER_PIXEL - 1);
    localparam logic [PH_W-1:0]  PH_MID  = PH_W'(CLKS_PER_PIXEL / 2);
    localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_LO    = CNT_W'(H_ACT_START);
    localparam logic [CNT_W-1:0] H_HI    = CNT_W'(H_ACT_START + H_ACTIVE);
    localparam logic [CNT_W-1:0] V_LO    = CNT_W'(V_ACT_START);
    localparam logic [CNT_W-1:0] V_HI    = CNT_W'(V_ACT_START + V_ACTIVE);

    // A sync pulse that reaches into the active area means the timing set is nonsense.
    if (H_SYNC >= H_ACT_START || V_SYNC >= V_ACT_START) begin : g_bad_timing
        $error("vga_sync_decoder: sync pulse overlaps the active region");
    end

    dec_state_t       state, state_d;
    logic             h_fall, v_fall;
    logic [RGB_W-1:0] rgb_meta, rgb_q;
    logic [PH_W-1:0]  phase;
    logic [CNT_W-1:0] h_cnt, v_cnt;
    logic             v_on_h;
    logic             h_wrap, v_wrap, h_act, v_act;
    logic             h_bad, v_bad, frame_end;
    logic             pix_valid, locked, frame_done, h_err, v_err;
    logic [RGB_W-1:0] pix_q;
    logic [SUM_W-1:0] frame_count;

    sync_edge_detect u_hsync (.clk(clk), .reset(reset), .sig(bus.hSync), .fall(h_fall));
    sync_edge_detect u_vsync (.clk(clk), .reset(reset), .sig(bus.vSync), .fall(v_fall));

    // Delay rgb through the same two stages as the syncs so samples line up with the counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            rgb_meta <= '0;
            rgb_q    <= '0;
        end else begin
            rgb_meta <= bus.rgb;
            rgb_q    <= rgb_meta;
        end
    end

    assign h_wrap = (phase == PH_LAST) && (h_cnt == H_LAST);
    assign v_wrap = h_wrap && (v_cnt == V_LAST);
    assign h_act  = (h_cnt >= H_LO) && (h_cnt < H_HI);
    assign v_act  = (v_cnt >= V_LO) && (v_cnt < V_HI);

    // Lock state register.
    always_ff @(posedge clk) begin
        if (reset) state <= SEARCH;
        else       state <= state_d;
    end

    // Next state and timing checks: while tracking, every sync edge must land
    // exactly on the counter wrap and every wrap must see its edge.
    always_comb begin
        state_d   = state;
        h_bad     = 1'b0;
        v_bad     = 1'b0;
        frame_end = 1'b0;
        case (state)
            SEARCH: if (v_fall) state_d = ALIGN;
            ALIGN:  if (h_fall) state_d = TRACK;
            TRACK: begin
                h_bad = (h_fall != h_wrap);
                v_bad = (v_fall != v_wrap);
                if (h_bad || v_bad) state_d = SEARCH;
                else if (v_fall)    frame_end = 1'b1;
            end
            default: state_d = SEARCH;
        endcase
    end

    // Position counters, lock/error flags, pixel sampling and frame bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase       <= '0;
            h_cnt       <= '0;
            v_cnt       <= '0;
            v_on_h      <= 1'b0;
            pix_valid   <= 1'b0;
            pix_q       <= '0;
            locked      <= 1'b0;
            frame_done  <= 1'b0;
            frame_count <= '0;
            h_err       <= 1'b0;
            v_err       <= 1'b0;
        end else begin
            pix_valid  <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                SEARCH: if (v_fall) begin
                    v_cnt  <= '0;
                    // Frame start usually coincides with a line start; the next
                    // hSync edge then begins line 1, not line 0.
                    v_on_h <= h_fall;
                end
                ALIGN: if (h_fall) begin
                    phase  <= '0;
                    h_cnt  <= '0;
                    locked <= 1'b1;
                    if (v_on_h) v_cnt <= CNT_W'(1);
                end
                TRACK: begin
                    if (h_bad || v_bad) begin
                        locked <= 1'b0;
                        if (h_bad) h_err <= 1'b1;
                        if (v_bad) v_err <= 1'b1;
                    end else begin
                        if (phase == PH_LAST) begin
                            phase <= '0;
                            if (h_cnt == H_LAST) begin
                                h_cnt <= '0;
                                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
                            end else begin
                                h_cnt <= h_cnt + 1'b1;
                            end
                        end else begin
                            phase <= phase + 1'b1;
                        end
                        // Sample mid-pixel, away from the rgb transitions.
                        if (phase == PH_MID && h_act && v_act) begin
                            pix_valid <= 1'b1;
                            pix_q     <= rgb_q;
                        end
                        if (frame_end) begin
                            frame_done  <= 1'b1;
                            frame_count <= frame_count + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef VGA_DECODE_CHECKSUM_EN
    logic [SUM_W-1:0] acc;
    logic [SUM_W-1:0] frame_sum;

    // Sum sampled pixels over a locked frame; the total is handed over before
    // any coincident pixel is added, and partial sums die when lock is lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc       <= '0;
            frame_sum <= '0;
        end else if (frame_end) begin
            frame_sum <= acc;
            acc       <= pix_valid ? SUM_W'(pix_q) : '0;
        end else if (state != TRACK) begin
            acc <= '0;
        end else if (pix_valid) begin
            acc <= acc + SUM_W'(pix_q);
        end
    end

    assign bus.frameSum = frame_sum;
`else
    assign bus.frameSum = '0;
`endif

    assign bus.hCount     = h_cnt;
    assign bus.vCount     = v_cnt;
    assign bus.pixValid   = pix_valid;
    assign bus.pixel      = pix_q;
    assign bus.locked     = locked;
    assign bus.frameDone  = frame_done;
    assign bus.frameCount = frame_count;
    assign bus.hErr       = h_err;
    assign bus.vErr       = v_err;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder using a shrunken timing set
// (20x10 pixels per frame, 8x5 active) so whole frames run quickly.
module tb_vga_sync_decoder;
    import vga_timing_pkg::*;

    localparam int CPP = 4;
    localparam int HT  = 20;
    localparam int HS  = 2;
    localparam int HAS = 4;
    localparam int HA  = 8;
    localparam int VT  = 10;
    localparam int VS  = 2;
    localparam int VAS = 2;
    localparam int VA  = 5;

`ifdef VGA_DECODE_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    vga_sync_decoder_if bus ();

    vga_sync_decoder #(
        .CLKS_PER_PIXEL(CPP), .H_TOTAL(HT), .H_SYNC(HS), .H_ACT_START(HAS), .H_ACTIVE(HA),
        .V_TOTAL(VT), .V_SYNC(VS), .V_ACT_START(VAS), .V_ACTIVE(VA)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Event monitor: counts strobes and records where the marker pixel shows up.
    int         fd_cnt = 0;
    int         pv_cnt = 0;
    int         mark_cnt = 0;
    int         wide_cnt = 0;
    logic [9:0] mark_h = '0;
    logic [9:0] mark_v = '0;
    bit         pv_d = 1'b0;
    bit         fd_d = 1'b0;

    always @(negedge clk) begin
        if (bus.pixValid === 1'b1) begin
            pv_cnt++;
            if (bus.pixel === 12'hF00) begin
                mark_cnt++;
                mark_h = bus.hCount;
                mark_v = bus.vCount;
            end
        end
        if (bus.frameDone === 1'b1) fd_cnt++;
        if ((bus.pixValid === 1'b1 && pv_d) || (bus.frameDone === 1'b1 && fd_d)) wide_cnt++;
        pv_d = (bus.pixValid === 1'b1);
        fd_d = (bus.frameDone === 1'b1);
    end

    // One frame of connector timing. long_y: line stretched by one pixel;
    // vs_start: first vSync-low line; (mark_x, mark_y): pixel driven as 12'hF00.
    // Blanking carries 12'h0F0 so any sampling outside the active area shows up.
    task automatic gen_frame(input logic [11:0] base, input int long_y, input int vs_start,
                             input int mark_x, input int mark_y);
        for (int y = 0; y < VT; y++) begin
            int len;
            len = (y == long_y) ? HT + 1 : HT;
            for (int x = 0; x < len; x++) begin
                @(negedge clk);
                bus.hSync = (x >= HS);
                bus.vSync = (((y - vs_start + VT) % VT) >= VS);
                if (x >= HAS && x < HAS + HA && y >= VAS && y < VAS + VA)
                    bus.rgb = (x == mark_x && y == mark_y) ? 12'hF00 : base;
                else
                    bus.rgb = 12'h0F0;
                repeat (CPP - 1) @(negedge clk);
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        bus.hSync = 1'b1;
        bus.vSync = 1'b1;
        bus.rgb   = 12'h0F0;
        repeat (3) @(negedge clk);
        if (bus.hCount !== 10'd0) begin errors++; $display("FAIL reset_hcount: got %0d want 0", bus.hCount); end
        checks++;
        if (bus.vCount !== 10'd0) begin errors++; $display("FAIL reset_vcount: got %0d want 0", bus.vCount); end
        checks++;
        if (bus.pixValid !== 1'b0) begin errors++; $display("FAIL reset_pixvalid: got %b want 0", bus.pixValid); end
        checks++;
        if (bus.pixel !== 12'h000) begin errors++; $display("FAIL reset_pixel: got %h want 000", bus.pixel); end
        checks++;
        if (bus.locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b want 0", bus.locked); end
        checks++;
        if (bus.frameDone !== 1'b0) begin errors++; $display("FAIL reset_framedone: got %b want 0", bus.frameDone); end
        checks++;
        if (bus.frameSum !== 16'h0000) begin errors++; $display("FAIL reset_framesum: got %h want 0000", bus.frameSum); end
        checks++;
        if (bus.frameCount !== 16'd0) begin errors++; $display("FAIL reset_framecount: got %0d want 0", bus.frameCount); end
        checks++;
        if (bus.hErr !== 1'b0 || bus.vErr !== 1'b0) begin
            errors++; $display("FAIL reset_errs: got h=%b v=%b want 0 0", bus.hErr, bus.vErr);
        end
        checks++;
        reset = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_lock;
        int fd0;
        fd0 = fd_cnt;
        gen_frame(12'h001, -1, 0, -1, -1);
        if (bus.locked !== 1'b1) begin errors++; $display("FAIL lock_frame1: got %b want 1", bus.locked); end
        checks++;
        gen_frame(12'h001, -1, 0, -1, -1);
        gen_frame(12'h001, -1, 0, -1, -1);
        if (fd_cnt - fd0 !== 2) begin errors++; $display("FAIL lock_framedone: got %0d pulses want 2", fd_cnt - fd0); end
        checks++;
        if (bus.frameCount !== 16'd2) begin errors++; $display("FAIL lock_framecount: got %0d want 2", bus.frameCount); end
        checks++;
        if (bus.hErr !== 1'b0 || bus.vErr !== 1'b0) begin
            errors++; $display("FAIL lock_errs: got h=%b v=%b want 0 0", bus.hErr, bus.vErr);
        end
        checks++;
        if (bus.frameSum !== (CSUM ? 16'h0028 : 16'h0000)) begin
            errors++; $display("FAIL lock_framesum: got %h want %h", bus.frameSum, CSUM ? 16'h0028 : 16'h0000);
        end
        checks++;
    endtask

    // 40 pixels of 12'hFFF = 163800, which wraps to 16'h7FD8.
    task automatic test_checksum;
        gen_frame(12'hFFF, -1, 0, -1, -1);
        gen_frame(12'h001, -1, 0, -1, -1);
        if (bus.frameSum !== (CSUM ? 16'h7FD8 : 16'h0000)) begin
            errors++; $display("FAIL csum_wrap: got %h want %h", bus.frameSum, CSUM ? 16'h7FD8 : 16'h0000);
        end
        checks++;
        if (bus.frameCount !== 16'd4) begin errors++; $display("FAIL csum_framecount: got %0d want 4", bus.frameCount); end
        checks++;
    endtask

    task automatic test_marker;
        int pv0, mk0;
        pv0 = pv_cnt;
        mk0 = mark_cnt;
        gen_frame(12'h001, -1, 0, HAS, VAS);
        if (mark_cnt - mk0 !== 1) begin errors++; $display("FAIL marker_seen: got %0d want 1", mark_cnt - mk0); end
        checks++;
        if (mark_h !== 10'(HAS) || mark_v !== 10'(VAS)) begin
            errors++; $display("FAIL marker_pos: got (%0d,%0d) want (%0d,%0d)", mark_h, mark_v, HAS, VAS);
        end
        checks++;
        if (pv_cnt - pv0 !== HA * VA) begin errors++; $display("FAIL marker_pixcount: got %0d want %0d", pv_cnt - pv0, HA * VA); end
        checks++;
        if (wide_cnt !== 0) begin errors++; $display("FAIL strobe_width: got %0d wide strobes want 0", wide_cnt); end
        checks++;
    endtask

    task automatic test_long_line;
        gen_frame(12'h001, 5, 0, -1, -1);
        if (bus.hErr !== 1'b1) begin errors++; $display("FAIL hline_herr: got %b want 1", bus.hErr); end
        checks++;
        if (bus.locked !== 1'b0) begin errors++; $display("FAIL hline_unlock: got %b want 0", bus.locked); end
        checks++;
        if (bus.vErr !== 1'b0) begin errors++; $display("FAIL hline_verr: got %b want 0", bus.vErr); end
        checks++;
        // Marker frame: 39 * 1 + 0xF00.
        if (bus.frameSum !== (CSUM ? 16'h0F27 : 16'h0000)) begin
            errors++; $display("FAIL hline_framesum: got %h want %h", bus.frameSum, CSUM ? 16'h0F27 : 16'h0000);
        end
        checks++;
        if (bus.frameCount !== 16'd6) begin errors++; $display("FAIL hline_framecount: got %0d want 6", bus.frameCount); end
        checks++;
        gen_frame(12'h001, -1, 0, -1, -1);
        if (bus.locked !== 1'b1) begin errors++; $display("FAIL hline_relock: got %b want 1", bus.locked); end
        checks++;
        if (bus.hErr !== 1'b1) begin errors++; $display("FAIL hline_sticky: got %b want 1", bus.hErr); end
        checks++;
        if (bus.frameCount !== 16'd6) begin errors++; $display("FAIL relock_framecount: got %0d want 6", bus.frameCount); end
        checks++;
    endtask

    task automatic test_vsync_moved;
        gen_frame(12'h001, -1, VT - 1, -1, -1);
        if (bus.vErr !== 1'b1) begin errors++; $display("FAIL vmove_verr: got %b want 1", bus.vErr); end
        checks++;
        if (bus.locked !== 1'b0) begin errors++; $display("FAIL vmove_unlock: got %b want 0", bus.locked); end
        checks++;
        if (bus.frameCount !== 16'd7) begin errors++; $display("FAIL vmove_framecount: got %0d want 7", bus.frameCount); end
        checks++;
        if (bus.frameSum !== (CSUM ? 16'h0028 : 16'h0000)) begin
            errors++; $display("FAIL vmove_framesum: got %h want %h", bus.frameSum, CSUM ? 16'h0028 : 16'h0000);
        end
        checks++;
    endtask

    task automatic test_reset_mid;
        fork
            gen_frame(12'h001, -1, 0, -1, -1);
            begin
                repeat (300) @(negedge clk);
                reset = 1'b1;
                @(negedge clk);
                if (bus.frameCount !== 16'd0) begin errors++; $display("FAIL midrst_framecount: got %0d want 0", bus.frameCount); end
                checks++;
                if (bus.hErr !== 1'b0 || bus.vErr !== 1'b0) begin
                    errors++; $display("FAIL midrst_errs: got h=%b v=%b want 0 0", bus.hErr, bus.vErr);
                end
                checks++;
                if (bus.locked !== 1'b0 || bus.hCount !== 10'd0 || bus.vCount !== 10'd0) begin
                    errors++; $display("FAIL midrst_track: got lock=%b h=%0d v=%0d want 0 0 0", bus.locked, bus.hCount, bus.vCount);
                end
                checks++;
                if (bus.pixValid !== 1'b0 || bus.pixel !== 12'h000 || bus.frameDone !== 1'b0 || bus.frameSum !== 16'h0000) begin
                    errors++; $display("FAIL midrst_data: got pv=%b px=%h fd=%b sum=%h want 0 000 0 0000",
                                       bus.pixValid, bus.pixel, bus.frameDone, bus.frameSum);
                end
                checks++;
                reset = 1'b0;
            end
        join
        gen_frame(12'h001, -1, 0, -1, -1);
        gen_frame(12'h001, -1, 0, -1, -1);
        if (bus.locked !== 1'b1) begin errors++; $display("FAIL midrst_relock: got %b want 1", bus.locked); end
        checks++;
        if (bus.frameCount !== 16'd1) begin errors++; $display("FAIL midrst_count: got %0d want 1", bus.frameCount); end
        checks++;
        if (bus.hErr !== 1'b0 || bus.vErr !== 1'b0) begin
            errors++; $display("FAIL midrst_clean: got h=%b v=%b want 0 0", bus.hErr, bus.vErr);
        end
        checks++;
        if (bus.frameSum !== (CSUM ? 16'h0028 : 16'h0000)) begin
            errors++; $display("FAIL midrst_framesum: got %h want %h", bus.frameSum, CSUM ? 16'h0028 : 16'h0000);
        end
        checks++;
    endtask

    initial begin
        test_reset();
        test_lock();
        test_checksum();
        test_marker();
        test_long_line();
        test_vsync_moved();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
